// File: rtl/tl_ul_buffer_if.sv
// TileLink-UL buffer bus bundle: the A and D handshake channels on both sides
// of the buffer. "slave" is the buffer's view; "master" is the surrounding
// environment's view.
interface tl_ul_buffer_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 5,
  parameter int SINK_W   = 1,
  parameter int SIZE_W   = 3
);
  localparam int AW = 6 + SIZE_W + SOURCE_W + ADDR_W + DATA_W/8 + DATA_W;
  localparam int DW = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;

  logic          a_in_valid;
  logic          a_in_ready;
  logic [AW-1:0] a_in_bits;
  logic          a_out_valid;
  logic          a_out_ready;
  logic [AW-1:0] a_out_bits;
  logic          d_in_valid;
  logic          d_in_ready;
  logic [DW-1:0] d_in_bits;
  logic          d_out_valid;
  logic          d_out_ready;
  logic [DW-1:0] d_out_bits;

  modport slave (
    input  a_in_valid, a_in_bits, a_out_ready,
    output a_in_ready, a_out_valid, a_out_bits,
    input  d_in_valid, d_in_bits, d_out_ready,
    output d_in_ready, d_out_valid, d_out_bits
  );

  modport master (
    output a_in_valid, a_in_bits, a_out_ready,
    input  a_in_ready, a_out_valid, a_out_bits,
    output d_in_valid, d_in_bits, d_out_ready,
    input  d_in_ready, d_out_valid, d_out_bits
  );
endinterface

// File: rtl/tl_ul_buffer.sv
// TileLink-UL buffer: two independent circular FIFOs, one for the A channel
// (master -> slave) and one for the D channel (slave -> master). Beats pass
// through untouched and in arrival order; bursts are just consecutive beats.
// Optional macro TL_UL_BUFFER_FLOW_EN: an empty queue forwards its input
// combinationally (flow-through); without it the latency is always >= 1.

// One channel queue: DEPTH entries, wrapping pointers and an occupancy count.
module tl_ul_buffer_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_bits_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_bits_o,
  output logic [4:0]   count_o
);
  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
  localparam logic [4:0]       DEPTH_C = 5'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             empty;
  logic             enq;
  logic             deq;

  assign empty      = (count_q == 5'd0);
  assign in_ready_o = (count_q < DEPTH_C);
  assign count_o    = count_q;
  assign deq        = out_ready_i && !empty;

`ifdef TL_UL_BUFFER_FLOW_EN
  // An empty queue shows the incoming beat directly; if it is taken in the
  // same cycle it never touches storage.
  assign out_valid_o = !empty || in_valid_i;
  assign out_bits_o  = empty ? in_bits_i : mem_q[rd_ptr_q];
  assign enq         = in_valid_i && in_ready_o && !(empty && out_ready_i);
`else
  assign out_valid_o = !empty;
  assign out_bits_o  = mem_q[rd_ptr_q];
  assign enq         = in_valid_i && in_ready_o;
`endif

  // Next pointers wrap at DEPTH-1 so non-power-of-two depths work; the count
  // holds when an enqueue and a dequeue coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the queue and overrides any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable once
  // the pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= in_bits_i;
  end
endmodule

module tl_ul_buffer #(
  parameter int DEPTH_A  = 2,
  parameter int DEPTH_D  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 5,
  parameter int SINK_W   = 1,
  parameter int SIZE_W   = 3
) (
  input  logic                clock,
  input  logic                reset,
  tl_ul_buffer_if.slave       bus,
  output logic [4:0]          a_count,
  output logic [4:0]          d_count
);
  localparam int AW = 6 + SIZE_W + SOURCE_W + ADDR_W + DATA_W/8 + DATA_W;
  localparam int DW = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;

  tl_ul_buffer_queue #(.DEPTH(DEPTH_A), .W(AW)) u_a_queue (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (bus.a_in_valid),
    .in_ready_o  (bus.a_in_ready),
    .in_bits_i   (bus.a_in_bits),
    .out_valid_o (bus.a_out_valid),
    .out_ready_i (bus.a_out_ready),
    .out_bits_o  (bus.a_out_bits),
    .count_o     (a_count)
  );

  tl_ul_buffer_queue #(.DEPTH(DEPTH_D), .W(DW)) u_d_queue (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (bus.d_in_valid),
    .in_ready_o  (bus.d_in_ready),
    .in_bits_i   (bus.d_in_bits),
    .out_valid_o (bus.d_out_valid),
    .out_ready_i (bus.d_out_ready),
    .out_bits_o  (bus.d_out_bits),
    .count_o     (d_count)
  );
endmodule

// File: tb/tb_tl_ul_buffer.sv
// Directed testbench for tl_ul_buffer (A depth 2, D depth 3). Works in both
// the default build and with TL_UL_BUFFER_FLOW_EN defined.
`timescale 1ns/1ps
module tb_tl_ul_buffer;
  localparam int DEPTH_A  = 2;
  localparam int DEPTH_D  = 3;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SOURCE_W = 5;
  localparam int SINK_W   = 1;
  localparam int SIZE_W   = 3;
  localparam int AW = 6 + SIZE_W + SOURCE_W + ADDR_W + DATA_W/8 + DATA_W;
  localparam int DW = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;
`ifdef TL_UL_BUFFER_FLOW_EN
  localparam logic FLOW = 1'b1;
`else
  localparam logic FLOW = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] a_count;
  logic [4:0] d_count;
  int         nChecks = 0;
  int         nFails  = 0;

  logic [AW-1:0] beatA;
  logic [AW-1:0] b [3];
  logic [DW-1:0] beatD;
  logic [DW-1:0] expQ [$];
  logic          dv, dr, inFire, outFire;
  logic [DW-1:0] db;
  int            sent, got;

  tl_ul_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SOURCE_W(SOURCE_W),
                    .SINK_W(SINK_W), .SIZE_W(SIZE_W)) bus ();

  tl_ul_buffer #(.DEPTH_A(DEPTH_A), .DEPTH_D(DEPTH_D), .ADDR_W(ADDR_W),
                 .DATA_W(DATA_W), .SOURCE_W(SOURCE_W), .SINK_W(SINK_W),
                 .SIZE_W(SIZE_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .a_count (a_count),
    .d_count (d_count)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] mkA(input logic [2:0] op, input int src,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    return {op, 3'd0, SIZE_W'(2), SOURCE_W'(src), addr, {(DATA_W/8){1'b1}}, data};
  endfunction

  function automatic logic [DW-1:0] mkD(input logic [2:0] op, input int src,
                                        input logic [DATA_W-1:0] data);
    return {op, 2'd0, SIZE_W'(2), SOURCE_W'(src), SINK_W'(0), 1'b0, data, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [AW-1:0] aB, input logic aR,
                               input logic dV, input logic [DW-1:0] dB, input logic dR);
    bus.a_in_valid  = aV;
    bus.a_in_bits   = aB;
    bus.a_out_ready = aR;
    bus.d_in_valid  = dV;
    bus.d_in_bits   = dB;
    bus.d_out_ready = dR;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset and idle state
    reset = 1'b1;
    applyStimulus(0, '0, 0, 0, '0, 0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("rst_a_out_valid", bus.a_out_valid, 1'b0);
    checkOutput("rst_d_out_valid", bus.d_out_valid, 1'b0);
    checkOutput("rst_a_in_ready", bus.a_in_ready, 1'b1);
    checkOutput("rst_d_in_ready", bus.d_in_ready, 1'b1);
    checkOutput("rst_a_count", a_count, 5'd0);
    checkOutput("rst_d_count", d_count, 5'd0);

    // Single Get beat through an empty A queue
    beatA = mkA(3'd4, 3, 32'h8000_0010, 32'h0);
    applyStimulus(1, beatA, 1, 0, '0, 0);
    checkOutput("get_valid_same_cycle", bus.a_out_valid, FLOW);
    tick();
    applyStimulus(0, '0, 1, 0, '0, 0);
    checkOutput("get_valid_next", bus.a_out_valid, !FLOW);
    checkOutput("get_bits_next", bus.a_out_bits, FLOW ? '0 : beatA);
    checkOutput("get_count_next", a_count, {4'd0, !FLOW});
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("get_count_drained", a_count, 5'd0);
    checkOutput("get_valid_drained", bus.a_out_valid, 1'b0);

    // A queue fills at two beats; third waits for the first dequeue
    for (int i = 0; i < 3; i++) b[i] = mkA(3'd0, i + 1, 32'h1000 + 4 * i, 32'hA0A0_0000 + i);
    applyStimulus(1, b[0], 0, 0, '0, 0);
    checkOutput("fill_ready0", bus.a_in_ready, 1'b1);
    tick();
    applyStimulus(1, b[1], 0, 0, '0, 0);
    checkOutput("fill_ready1", bus.a_in_ready, 1'b1);
    checkOutput("fill_count1", a_count, 5'd1);
    tick();
    applyStimulus(1, b[2], 0, 0, '0, 0);
    checkOutput("full_ready", bus.a_in_ready, 1'b0);
    checkOutput("full_count", a_count, 5'd2);
    tick();
    applyStimulus(1, b[2], 1, 0, '0, 0);
    checkOutput("full_ready_indep", bus.a_in_ready, 1'b0);
    checkOutput("full_out_b0", bus.a_out_bits, b[0]);
    checkOutput("full_count_held", a_count, 5'd2);
    tick();
    applyStimulus(1, b[2], 1, 0, '0, 0);
    checkOutput("after_deq_ready", bus.a_in_ready, 1'b1);
    checkOutput("after_deq_out_b1", bus.a_out_bits, b[1]);
    checkOutput("after_deq_count", a_count, 5'd1);
    tick();
    applyStimulus(0, '0, 1, 0, '0, 0);
    checkOutput("third_out_b2", bus.a_out_bits, b[2]);
    checkOutput("third_count", a_count, 5'd1);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("fill_drained_count", a_count, 5'd0);
    checkOutput("fill_drained_valid", bus.a_out_valid, 1'b0);

    // Simultaneous enqueue/dequeue at count 1 for 8 cycles
    applyStimulus(1, mkA(3'd1, 7, 32'h2000, 32'h5A00_0000), 0, 0, '0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, mkA(3'd1, 7, 32'h2000 + i + 1, 32'h5A00_0000 + i + 1), 1, 0, '0, 0);
      checkOutput("steady_bits", bus.a_out_bits, mkA(3'd1, 7, 32'h2000 + i, 32'h5A00_0000 + i));
      checkOutput("steady_count", a_count, 5'd1);
      tick();
    end
    applyStimulus(0, '0, 1, 0, '0, 0);
    checkOutput("steady_last_bits", bus.a_out_bits, mkA(3'd1, 7, 32'h2008, 32'h5A00_0008));
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("steady_drained", a_count, 5'd0);

    // Empty D queue with a waiting consumer
    beatD = mkD(3'd1, 2, 32'hDEAD_BEEF);
    applyStimulus(0, '0, 0, 1, beatD, 1);
`ifdef TL_UL_BUFFER_FLOW_EN
    checkOutput("flow_valid", bus.d_out_valid, 1'b1);
    checkOutput("flow_data", bus.d_out_bits[DATA_W:1], 32'hDEAD_BEEF);
    checkOutput("flow_count", d_count, 5'd0);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("flow_count_after", d_count, 5'd0);
    checkOutput("flow_valid_after", bus.d_out_valid, 1'b0);
`else
    checkOutput("lat_valid_same_cycle", bus.d_out_valid, 1'b0);
    checkOutput("lat_count_same_cycle", d_count, 5'd0);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("lat_valid_next", bus.d_out_valid, 1'b1);
    checkOutput("lat_data_next", bus.d_out_bits[DATA_W:1], 32'hDEAD_BEEF);
    checkOutput("lat_count_next", d_count, 5'd1);
    applyStimulus(0, '0, 0, 0, '0, 1);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("lat_drained", d_count, 5'd0);
`endif

    // Reset with two beats queued; handshake during reset is ignored
    applyStimulus(0, '0, 0, 1, mkD(3'd0, 1, 32'h1111_1111), 0);
    tick();
    applyStimulus(0, '0, 0, 1, mkD(3'd0, 2, 32'h2222_2222), 0);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("pre_rst_d_count", d_count, 5'd2);
    reset = 1'b1;
    applyStimulus(0, '0, 0, 1, mkD(3'd0, 3, 32'h3333_3333), 1);
    tick();
    reset = 1'b0;
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("mid_rst_d_valid", bus.d_out_valid, 1'b0);
    checkOutput("mid_rst_d_count", d_count, 5'd0);
    checkOutput("mid_rst_d_ready", bus.d_in_ready, 1'b1);
    beatD = mkD(3'd1, 9, 32'h0F0F_0F0F);
    applyStimulus(0, '0, 0, 1, beatD, 0);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("post_rst_fresh_beat", bus.d_out_bits, beatD);
    checkOutput("post_rst_count", d_count, 5'd1);
    applyStimulus(0, '0, 0, 0, '0, 1);
    tick();
    applyStimulus(0, '0, 0, 0, '0, 0);
    checkOutput("post_rst_drained", d_count, 5'd0);
    checkOutput("post_rst_valid", bus.d_out_valid, 1'b0);

    // Ten D beats with random valid/ready against a scoreboard
    sent = 0;
    got  = 0;
    dv   = 1'b0;
    db   = '0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      if (!dv && sent < 10 && $urandom_range(0, 1) == 1) begin
        dv = 1'b1;
        db = mkD(3'd1, sent, 32'h3000_0000 + sent);
      end
      dr = ($urandom_range(0, 2) != 0);
      applyStimulus(0, '0, 0, dv, db, dr);
      inFire  = dv && bus.d_in_ready;
      outFire = bus.d_out_valid && dr;
      if (inFire) begin
        expQ.push_back(db);
        sent++;
      end
      if (outFire) begin
        if (expQ.size() == 0) begin
          checkOutput("rand_spurious_valid", bus.d_out_valid, 1'b0);
        end else begin
          checkOutput("rand_order", bus.d_out_bits, expQ.pop_front());
          got++;
        end
      end
      tick();
      if (inFire) dv = 1'b0;
      checkOutput("rand_count", d_count, expQ.size());
    end
    checkOutput("rand_all_received", got, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/tl_ul_buffer.md
TL_UL_BUFFER -- requirements
Module: tl_ul_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH_A, default 2: A-channel queue entries, legal range 1..16.
REQ-002 The block SHALL have parameter DEPTH_D, default 2: D-channel queue entries, legal range 1..16.
REQ-003 The block SHALL have parameter ADDR_W, default 32: A address width.
REQ-004 The block SHALL have parameter DATA_W, default 32: data width, a multiple of 8.
REQ-005 The block SHALL have parameter SOURCE_W, default 5: source ID width.
REQ-006 The block SHALL have parameter SINK_W, default 1: sink ID width.
REQ-007 The block SHALL have parameter SIZE_W, default 3: size width.
REQ-008 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-010 The block SHALL have ports a_in_valid (input, 1), a_in_ready (output, 1) and a_in_bits (input, AW): master-side A channel. AW = 6+SIZE_W+SOURCE_W+ADDR_W+DATA_W/8+DATA_W, packed MSB→LSB as {opcode[3], param[3], size, source, address, mask, data}.
REQ-011 The block SHALL have ports a_out_valid (output, 1), a_out_ready (input, 1) and a_out_bits (output, AW): slave-side A channel.
REQ-012 The block SHALL have ports d_in_valid (input, 1), d_in_ready (output, 1) and d_in_bits (input, DW): slave-side D channel. DW = 3+2+SIZE_W+SOURCE_W+SINK_W+1+DATA_W+1, packed MSB→LSB as {opcode, param, size, source, sink, denied, data, corrupt}.
REQ-013 The block SHALL have ports d_out_valid (output, 1), d_out_ready (input, 1) and d_out_bits (output, DW): master-side D channel.
REQ-014 The block SHALL have outputs a_count and d_count, each 5 bits: current queue occupancy.

Function
REQ-015 Each channel SHALL be an independent circular FIFO holding DEPTH entries, with write pointer, read pointer and occupancy count.
REQ-016 Handshakes: a transfer occurs when valid && ready on the same edge; valid is never gated by ready; bits are held stable while valid && !ready.
REQ-017 Ready: in_ready = (count < DEPTH); combinationally independent of out_ready (no pipe-through when full).
REQ-018 Valid and bits: out_valid = (count != 0); out_bits = entry[rd_ptr], registered storage only (macro absent).
REQ-019 Latency: with the macro absent, an enqueued beat SHALL appear on out no earlier than the next cycle (latency 1).
REQ-020 Count update: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue; the count never exceeds DEPTH or falls below 0.
REQ-021 Pointer wrap: each pointer increments on its own transfer and wraps from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-022 Full with out_ready=1: the dequeue occurs, the enqueue is refused, and in_ready rises the next cycle.
REQ-023 Empty with in_valid=1: the beat is stored, and out_valid rises the next cycle (macro absent).
REQ-024 Ordering: beats SHALL leave in arrival order per channel; A and D never interact; no field is modified.
REQ-025 Multi-beat bursts (size > log2(DATA_W/8)) SHALL be passed beat by beat with no burst awareness.

Reset
REQ-026 On reset=1 at a clock edge, pointers and counts SHALL go to 0, so a_out_valid=0, d_out_valid=0, a_in_ready=1, d_in_ready=1, a_count=0 and d_count=0 from the next cycle.
REQ-027 Reset mid-operation SHALL discard all queued beats; the storage array is not reset and its contents are don't-care.
REQ-028 A handshake in a cycle where reset=1 SHALL be ignored.

Configuration
REQ-029 Macro TL_UL_BUFFER_FLOW_EN: when defined, an empty queue with in_valid=1 SHALL drive out_valid=1 and out_bits=in_bits combinationally in the same cycle.
REQ-030 With TL_UL_BUFFER_FLOW_EN defined, if out_ready=1 in that cycle the beat SHALL bypass the storage and count/pointers are unchanged; otherwise the beat is stored normally.
REQ-031 Without TL_UL_BUFFER_FLOW_EN there SHALL be no input-to-output combinational path, so latency is always ≥1.

Verification
REQ-032 Reset, then a_in_valid=1 with opcode=4 (Get), address=0x8000_0010, source=3, a_out_ready=1 -> a_out_valid=1 one cycle later with identical bits; a_count goes 0→1→0.
REQ-033 DEPTH_A=2, a_out_ready=0, three back-to-back beats -> the first two accepted, a_in_ready=0 after the second, a_count=2; release a_out_ready -> beats emerge in order and the third is accepted the cycle after the first dequeue.
REQ-034 DEPTH_D=3, 10 beats with random valid/ready -> output sequence equals input sequence, pointer wrap exercised, and d_count never exceeds 3.
REQ-035 Queue holding 2 beats, assert reset for 1 cycle -> d_out_valid=0 and d_count=0 next cycle, and the stale beats never appear.
REQ-036 With TL_UL_BUFFER_FLOW_EN, empty queue, d_in_valid=1 with data=0xDEADBEEF, d_out_ready=1 -> d_out_valid=1 and data=0xDEADBEEF in the same cycle, d_count stays 0.
REQ-037 Simultaneous enqueue and dequeue at count=1 for 8 cycles -> count stays 1 and data order is preserved.
